// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file
//
// Register file sitting between decode (reads, destination allocation) and
// writeback (two write ports). It offers combinational read ports with
// optional same-cycle write forwarding, a per-register busy scoreboard for
// hazard detection, and a sequential clear engine that zeroes every register
// one per cycle on pipeline flush / context reset.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   rs_addr   NRP read addresses, port p at [p*AW +: AW]
//   rs_data   NRP read data words, port p at [p*XLEN +: XLEN]
//   rs_busy   scoreboard busy flag seen by each read port
//   we0/wa0/wd0  write port 0
//   we1/wa1/wd1  write port 1 (wins over port 0 on an address clash)
//   alloc_en/alloc_rd  mark a destination register as pending
//   clr_req   start a sequential clear
//   clr_busy  clear engine active
//   clr_done  one-cycle pulse after the last register has been cleared
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRP      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [AW-1:0] START_IDX = (ZERO_REG != 0) ? AW'(1) : '0;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;
    logic            clr_done_nxt;

    logic            idle;
    logic            acc0, acc1, alloc_ok;

    assign idle = (state == ST_IDLE);

    // Writes and allocations are only honoured while idle; the zero register
    // silently swallows writes and allocations when hardwired.
    assign acc0     = we0 && idle && !((ZERO_REG != 0) && (wa0 == '0));
    assign acc1     = we1 && idle && !((ZERO_REG != 0) && (wa1 == '0));
    assign alloc_ok = alloc_en && idle && !((ZERO_REG != 0) && (alloc_rd == '0));

    assign clr_busy = (state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Clear FSM: next state / index / done pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        clr_idx_nxt  = clr_idx;
        clr_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = START_IDX;
                end
            end
            ST_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_nxt    = ST_IDLE;
                    clr_done_nxt = 1'b1;
                end else begin
                    clr_idx_nxt = clr_idx + AW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_idx  <= AW'(1);
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            clr_done <= clr_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: a write retires the pending producer, but an allocation
    // on the same edge names a newer producer, so the set is applied last.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        if (state == ST_CLEAR) begin
            busy_nxt[clr_idx] = 1'b0;
        end else begin
            if (acc0)     busy_nxt[wa0]      = 1'b0;
            if (acc1)     busy_nxt[wa1]      = 1'b0;
            if (alloc_ok) busy_nxt[alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // ------------------------------------------------------------------
    // Register array: port 1 is written after port 0 so it wins on a clash.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == ST_CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            if (acc0) regs[wa0] <= wd0;
            if (acc1) regs[wa1] <= wd1;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports. acc0/acc1 are already false in CLEAR, so
    // forwarding never applies during a clear.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit0, hit1;
        logic [XLEN-1:0] rd;

        assign ra   = rs_addr[p*AW +: AW];
        assign hit0 = (BYPASS != 0) && acc0 && (wa0 == ra);
        assign hit1 = (BYPASS != 0) && acc1 && (wa1 == ra);

        always_comb begin
            rd = regs[ra];
            if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
            if (hit0) rd = wd0;
            if (hit1) rd = wd1;
        end

        assign rs_data[p*XLEN +: XLEN] = rd;
        assign rs_busy[p]              = busy[ra] & ~(hit0 | hit1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- directed testbench for regfile_mp.
// Two instances share all inputs: u_dut forwards writes (BYPASS=1) and
// u_nb does not (BYPASS=0). Both hardwire register 0.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRP = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRP*AW-1:0]   rs_addr = '0;
    logic                we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]       wa0 = '0, wa1 = '0;
    logic [XLEN-1:0]     wd0 = '0, wd1 = '0;
    logic                alloc_en = 1'b0;
    logic [AW-1:0]       alloc_rd = '0;
    logic                clr_req = 1'b0;

    logic [NRP*XLEN-1:0] rd_b, rd_nb;
    logic [NRP-1:0]      bz_b, bz_nb;
    logic                cb_b, cd_b, cb_nb, cd_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rd_b), .rs_busy(bz_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .clr_req(clr_req),
        .clr_busy(cb_b), .clr_done(cd_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0), .ZERO_REG(1)) u_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rd_nb), .rs_busy(bz_nb),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .clr_req(clr_req),
        .clr_busy(cb_nb), .clr_done(cd_nb)
    );

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic test_reset();
        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {AW'(a), AW'(a)};
            #1;
            n_cmp++;
            if ({rd_b, rd_nb} !== '0 || {bz_b, bz_nb} !== 4'b0 || {cb_b, cb_nb, cd_b, cd_nb} !== 4'b0) begin
                n_bad++;
                $display("FAIL reset_state addr=%0d: data=%h/%h busy=%b/%b clr=%b%b%b%b, required all 0",
                         a, rd_b, rd_nb, bz_b, bz_nb, cb_b, cb_nb, cd_b, cd_nb);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        rs_addr = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (rd_b[31:0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL bypass_same_cycle: got %h, required deadbeef", rd_b[31:0]);
        end
        n_cmp++;
        if (rd_nb[31:0] !== 32'h0) begin
            n_bad++;
            $display("FAIL nobypass_same_cycle: got %h, required 00000000", rd_nb[31:0]);
        end
        tick();
        we0 = 1'b0;
        #1;
        n_cmp++;
        if (rd_b[31:0] !== 32'hDEADBEEF || rd_nb[31:0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_visible_next: got %h/%h, required deadbeef", rd_b[31:0], rd_nb[31:0]);
        end
    endtask

    task automatic test_priority();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222;
        rs_addr = {5'd7, 5'd0};
        #1;
        n_cmp++;
        if (rd_b[63:32] !== 32'h2222) begin
            n_bad++;
            $display("FAIL bypass_priority: got %h, required 00002222", rd_b[63:32]);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_b[63:32] !== 32'h2222 || rd_nb[63:32] !== 32'h2222) begin
            n_bad++;
            $display("FAIL write_priority: got %h/%h, required 00002222", rd_b[63:32], rd_nb[63:32]);
        end
        // write to the hardwired zero register
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF;
        rs_addr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd_b[31:0] !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_reg_no_bypass: got %h, required 00000000", rd_b[31:0]);
        end
        tick();
        we0 = 1'b0;
        #1;
        n_cmp++;
        if (rd_b[31:0] !== 32'h0 || rd_nb[31:0] !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_reg_write: got %h/%h, required 00000000", rd_b[31:0], rd_nb[31:0]);
        end
        // distinct addresses on both ports in one cycle
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
        tick();
        idle_inputs();
        rs_addr = {5'd4, 5'd3};
        #1;
        n_cmp++;
        if (rd_nb !== {32'h44, 32'h33}) begin
            n_bad++;
            $display("FAIL dual_write: got %h, required 0000004400000033", rd_nb);
        end
    endtask

    task automatic test_scoreboard();
        alloc_en = 1'b1; alloc_rd = 5'd9;
        rs_addr = {5'd9, 5'd9};
        #1;
        n_cmp++;
        if ({bz_b, bz_nb} !== 4'b0000) begin
            n_bad++;
            $display("FAIL busy_before_alloc_edge: got %b/%b, required 00/00", bz_b, bz_nb);
        end
        tick();
        alloc_en = 1'b0;
        #1;
        n_cmp++;
        if ({bz_b, bz_nb} !== 4'b1111) begin
            n_bad++;
            $display("FAIL busy_after_alloc: got %b/%b, required 11/11", bz_b, bz_nb);
        end
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        #1;
        n_cmp++;
        if (bz_b !== 2'b00 || bz_nb !== 2'b11) begin
            n_bad++;
            $display("FAIL busy_during_write: got %b/%b, required 00/11", bz_b, bz_nb);
        end
        tick();
        we0 = 1'b0;
        #1;
        n_cmp++;
        if ({bz_b, bz_nb} !== 4'b0000) begin
            n_bad++;
            $display("FAIL busy_after_write: got %b/%b, required 00/00", bz_b, bz_nb);
        end
        // allocation and write on the same edge: set wins
        alloc_en = 1'b1; alloc_rd = 5'd9;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hAA;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({bz_b, bz_nb} !== 4'b1111 || rd_nb[31:0] !== 32'hAA) begin
            n_bad++;
            $display("FAIL alloc_write_same_edge: busy %b/%b data %h, required 11/11 data 000000aa",
                     bz_b, bz_nb, rd_nb[31:0]);
        end
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9;
        tick();
        we0 = 1'b0;
        // allocation of the zero register is ignored
        alloc_en = 1'b1; alloc_rd = 5'd0;
        tick();
        alloc_en = 1'b0;
        rs_addr = {5'd9, 5'd0};
        #1;
        n_cmp++;
        if ({bz_b, bz_nb} !== 4'b0000) begin
            n_bad++;
            $display("FAIL zero_reg_alloc: got %b/%b, required 00/00", bz_b, bz_nb);
        end
    endtask

    task automatic test_clear();
        int cyc;
        for (int i = 1; i < NREGS; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'(i);
            tick();
        end
        we0 = 1'b0;
        alloc_en = 1'b1; alloc_rd = 5'd12;
        tick();
        alloc_en = 1'b0;
        rs_addr = {5'd12, 5'd31};
        #1;
        n_cmp++;
        if (rd_nb !== {32'd12, 32'd31} || bz_nb !== 2'b10) begin
            n_bad++;
            $display("FAIL fill_before_clear: data %h busy %b, required 0000000c0000001f busy 10", rd_nb, bz_nb);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cyc = 0;
        while ((cb_b === 1'b1) && cyc < 40) begin
            if (cyc == 10) begin
                // regs 1..10 are cleared by now; the dropped write/alloc must not show
                rs_addr = {5'd20, 5'd3};
                we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5555;
                alloc_en = 1'b1; alloc_rd = 5'd25;
                #1;
                n_cmp++;
                if (rd_b !== {32'd20, 32'd0} || rd_nb !== {32'd20, 32'd0}) begin
                    n_bad++;
                    $display("FAIL read_mid_clear: got %h/%h, required 0000001400000000", rd_b, rd_nb);
                end
            end
            if (cd_b !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_early: clr_done=1 at clear cycle %0d, required 0", cyc);
            end
            tick();
            idle_inputs();
            cyc++;
        end
        n_cmp++;
        if (cyc !== 31) begin
            n_bad++;
            $display("FAIL clear_latency: got %0d cycles, required 31", cyc);
        end
        n_cmp++;
        if ({cd_b, cd_nb, cb_b, cb_nb} !== 4'b1100) begin
            n_bad++;
            $display("FAIL clr_done_pulse: done %b%b busy %b%b, required done 11 busy 00", cd_b, cd_nb, cb_b, cb_nb);
        end
        tick();
        n_cmp++;
        if ({cd_b, cd_nb} !== 2'b00) begin
            n_bad++;
            $display("FAIL clr_done_single: got %b%b, required 00", cd_b, cd_nb);
        end
        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {AW'(a), AW'(a)};
            #1;
            n_cmp++;
            if ({rd_b, rd_nb} !== '0 || {bz_b, bz_nb} !== 4'b0) begin
                n_bad++;
                $display("FAIL after_clear addr=%0d: data %h/%h busy %b/%b, required 0", a, rd_b, rd_nb, bz_b, bz_nb);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        logic seen_done;
        for (int i = 28; i < NREGS; i++) begin
            we1 = 1'b1; wa1 = AW'(i); wd1 = 32'hA0 + 32'(i);
            tick();
        end
        we1 = 1'b0;
        alloc_en = 1'b1; alloc_rd = 5'd30;
        tick();
        alloc_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cyc = 0;
        while ((cb_b === 1'b1) && cyc < 10) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc !== 10 || cb_b !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_running: reached %0d cycles busy=%b, required 10 busy=1", cyc, cb_b);
        end
        rst_n = 1'b0;
        rs_addr = {5'd30, 5'd31};
        #1;
        n_cmp++;
        if ({cb_b, cb_nb, cd_b, cd_nb} !== 4'b0000 || {rd_b, rd_nb} !== '0 || {bz_b, bz_nb} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: clr %b%b%b%b data %h/%h busy %b/%b, required all 0",
                     cb_b, cb_nb, cd_b, cd_nb, rd_b, rd_nb, bz_b, bz_nb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (cd_b === 1'b1 || cd_nb === 1'b1 || cb_b === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_bad++;
            $display("FAIL no_done_after_reset: clear activity seen=%b, required 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write, dual-read core register file. It adds configurable width, depth and port counts, dual write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard for pipeline hazard checks. It also has a hardware sequential-clear engine used on pipeline flush and context reset. It sits between the decode stage (reads, allocates) and the writeback stages (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >= 4); AW = clog2(NREGS) is a localparam
NRP, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads see registered contents only
ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never busy)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_addr  in  NRP*AW  read addresses, port p at [p*AW +: AW]
rs_data  out  NRP*XLEN  read data, port p at [p*XLEN +: XLEN]
rs_busy  out  NRP  scoreboard busy flag for each read address
we0  in  1  write port 0 enable
wa0  in  AW  write port 0 address
wd0  in  XLEN  write port 0 data
we1  in  1  write port 1 enable (higher priority)
wa1  in  AW  write port 1 address
wd1  in  XLEN  write port 1 data
alloc_en  in  1  mark destination register pending
alloc_rd  in  AW  register to mark busy
clr_req  in  1  start sequential clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, busy[] all 0, FSM IDLE, clear index 1, clr_busy 0, clr_done 0.
- Read ports are combinational.
  - rs_data = reg[addr]; address 0 returns 0 when ZERO_REG=1.
  - BYPASS=1: if an accepted write this cycle targets addr, return that write's data. wa1 beats wa0 when both match.
  - BYPASS=1: rs_busy = busy[addr] AND NOT(accepted write this cycle to addr).
  - BYPASS=0: rs_busy = busy[addr]; new data is visible on the cycle after the write edge.
- Writes are registered on the rising edge.
  - A write is accepted when weN=1, FSM=IDLE, and not (ZERO_REG=1 and waN=0).
  - Both ports accepted with wa0==wa1: port 1 data is stored.
  - Distinct addresses: both are stored in the same cycle.
- Scoreboard (busy[NREGS] flops):
  - An accepted write clears busy[waN] on the next edge.
  - alloc_en=1 in IDLE sets busy[alloc_rd] on the next edge. Ignored for reg 0 when ZERO_REG=1.
  - Same edge alloc and write to the same register: set wins (new producer pending).
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at the edge; index loads the start value (1 if ZERO_REG else 0).
  - CLEAR: each cycle writes 0 to reg[index], clears busy[index], then increments the index.
  - At index = NREGS-1: write, go to IDLE, clr_done=1 for exactly one cycle.
  - Latency: NREGS-1 cycles in CLEAR (NREGS if ZERO_REG=0).
  - clr_busy=1 exactly while in CLEAR.
  - In CLEAR, we0, we1, alloc_en and clr_req are ignored (dropped, not queued).
  - Reads stay live during CLEAR; already-cleared registers read 0, others hold their old values. Bypass never applies during CLEAR.
  - clr_req held high after done: re-enters CLEAR on the next edge.
- Reset mid-clear: immediate return to IDLE with all state zeroed; no clr_done pulse.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset, then read addr 0..31 on both ports -> all rs_data 0, rs_busy 0, clr_busy 0.
- we0 wa0=5 wd0=0xDEADBEEF, rs_addr0=5 same cycle -> BYPASS=1 returns 0xDEADBEEF same cycle; BYPASS=0 returns 0 that cycle and 0xDEADBEEF the next.
- we0 and we1 both to addr 7, wd0=0x1111, wd1=0x2222 -> reg7 reads 0x2222; we0 wa0=0 wd0=0xFFFF -> reg0 still reads 0.
- alloc_en alloc_rd=9 -> rs_busy for 9 is 1 next cycle; write 9 -> busy 0 after the edge. Alloc and write 9 on the same edge -> busy stays 1.
- Fill regs 1..31 with their index, pulse clr_req -> clr_busy high for 31 cycles, then a single clr_done pulse, all reads 0. A we1 issued mid-clear is dropped.
- Start a clear, assert rst_n=0 at clear cycle 10 -> clr_busy drops immediately, no clr_done, all registers and busy flags 0.
